// File: rtl/branch_resolve.sv
// Branch resolution stage: carries predictions from D through E to M, checks them against outcomes,
// drives predictor update and redirect, and holds off wrong-path resolution while the front end refills.
module branch_resolve #(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 stallM,
  input  logic                 flushM,
  input  logic                 branchD,
  input  logic                 pred_takeD,
  input  logic [31:0]          pcD,
  input  logic                 actual_takeE,
  input  logic [31:0]          targetE,
  output logic                 branchM,
  output logic                 actual_takeM,
  output logic [31:0]          pcM,
  output logic                 mispredictM,
  output logic                 flush_req,
  output logic [31:0]          redirect_pc,
  output logic                 recovering,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  localparam logic [3:0]           RECOVER_LOAD = 4'(RECOVER_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1'b1);

  logic                 branchE_r;
  logic                 predTakeE_r;
  logic [31:0]          pcE_r;
  logic                 branchM_r;
  logic                 predTakeM_r;
  logic [31:0]          pcM_r;
  logic                 actualTakeM_r;
  logic [31:0]          targetM_r;
  logic [0:0]           state_r;
  logic [0:0]           stateNext_s;
  logic [3:0]           recoverCnt_r;
  logic [3:0]           recoverCntNext_s;
  logic [CNT_WIDTH-1:0] branchCnt_r;
  logic [CNT_WIDTH-1:0] mispredCnt_r;
  logic                 liveM_s;
  logic                 mispredM_s;
  logic [31:0]          redirect_s;

  // M-stage resolution: a branch only counts when the FSM is idle and M is advancing
  always_comb begin
    liveM_s    = branchM_r & (state_r == IDLE) & ~stallM;
    mispredM_s = liveM_s & (predTakeM_r ^ actualTakeM_r);
    redirect_s = 32'd0;
    if (mispredM_s) begin
      redirect_s = actualTakeM_r ? targetM_r : (pcM_r + 32'd4);
    end else begin
      redirect_s = 32'd0;
    end
  end

  assign branchM      = liveM_s;
  assign actual_takeM = actualTakeM_r;
  assign pcM          = pcM_r;
  assign mispredictM  = mispredM_s;
  assign flush_req    = mispredM_s;
  assign redirect_pc  = redirect_s;
  assign recovering   = (state_r == RECOVER);
  assign branch_cnt   = branchCnt_r;
  assign mispred_cnt  = mispredCnt_r;

  // D->E pipeline register; a redirect kills the wrong-path instruction in D
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchE_r   <= 1'b0;
      predTakeE_r <= 1'b0;
      pcE_r       <= 32'd0;
    end else if (flushE || mispredM_s) begin
      branchE_r   <= 1'b0;
      predTakeE_r <= 1'b0;
      pcE_r       <= 32'd0;
    end else if (!stallE) begin
      branchE_r   <= branchD;
      predTakeE_r <= pred_takeD;
      pcE_r       <= pcD;
    end
  end

  // E->M pipeline register; flush wins over stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchM_r     <= 1'b0;
      predTakeM_r   <= 1'b0;
      pcM_r         <= 32'd0;
      actualTakeM_r <= 1'b0;
      targetM_r     <= 32'd0;
    end else if (flushM || mispredM_s) begin
      branchM_r     <= 1'b0;
      predTakeM_r   <= 1'b0;
      pcM_r         <= 32'd0;
      actualTakeM_r <= 1'b0;
      targetM_r     <= 32'd0;
    end else if (!stallM) begin
      branchM_r     <= branchE_r;
      predTakeM_r   <= predTakeE_r;
      pcM_r         <= pcE_r;
      actualTakeM_r <= actual_takeE;
      targetM_r     <= targetE;
    end
  end

  // Recovery FSM next state; the countdown runs regardless of stalls
  always_comb begin
    stateNext_s      = state_r;
    recoverCntNext_s = recoverCnt_r;
    case (state_r)
      IDLE: begin
        if (mispredM_s) begin
          stateNext_s      = RECOVER;
          recoverCntNext_s = RECOVER_LOAD;
        end else begin
          stateNext_s      = IDLE;
          recoverCntNext_s = 4'd0;
        end
      end
      RECOVER: begin
        if (recoverCnt_r <= 4'd1) begin
          stateNext_s      = IDLE;
          recoverCntNext_s = 4'd0;
        end else begin
          stateNext_s      = RECOVER;
          recoverCntNext_s = recoverCnt_r - 4'd1;
        end
      end
      default: begin
        stateNext_s      = IDLE;
        recoverCntNext_s = 4'd0;
      end
    endcase
  end

  // Recovery FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      recoverCnt_r <= 4'd0;
    end else begin
      state_r      <= stateNext_s;
      recoverCnt_r <= recoverCntNext_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchCnt_r  <= '0;
      mispredCnt_r <= '0;
    end else begin
      if (liveM_s && (branchCnt_r != CNT_MAX)) begin
        branchCnt_r <= branchCnt_r + CNT_ONE;
      end
      if (mispredM_s && (mispredCnt_r != CNT_MAX)) begin
        mispredCnt_r <= mispredCnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios then random traffic against a
// slot-level pipeline model; a 3-bit-counter instance exercises saturation.
module tb_branch_resolve;

  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallE, flushE, stallM, flushM;
  logic        branchD, pred_takeD, actual_takeE;
  logic [31:0] pcD, targetE;

  logic        branchM, actual_takeM, mispredictM, flush_req, recovering;
  logic [31:0] pcM, redirect_pc, branch_cnt, mispred_cnt;

  logic        sBranchM, sActualTakeM, sMispredictM, sFlushReq, sRecovering;
  logic [31:0] sPcM, sRedirectPc;
  logic [2:0]  sBranchCnt, sMispredCnt;

  always #5 clk = ~clk;

  branch_resolve #(.RECOVER_CYCLES(RC), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
    .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD), .actual_takeE(actual_takeE),
    .targetE(targetE), .branchM(branchM), .actual_takeM(actual_takeM), .pcM(pcM),
    .mispredictM(mispredictM), .flush_req(flush_req), .redirect_pc(redirect_pc),
    .recovering(recovering), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve #(.RECOVER_CYCLES(RC), .CNT_WIDTH(3)) dutSat (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
    .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD), .actual_takeE(actual_takeE),
    .targetE(targetE), .branchM(sBranchM), .actual_takeM(sActualTakeM), .pcM(sPcM),
    .mispredictM(sMispredictM), .flush_req(sFlushReq), .redirect_pc(sRedirectPc),
    .recovering(sRecovering), .branch_cnt(sBranchCnt), .mispred_cnt(sMispredCnt)
  );

  typedef struct { bit v; bit pred; logic [31:0] pc; } eSlot_t;
  typedef struct { bit v; bit pred; logic [31:0] pc; bit act; logic [31:0] tgt; } mSlot_t;

  eSlot_t mE;
  mSlot_t mM;
  int     squashLeft;
  int     bcnt, mcnt;
  int     nCmp = 0;
  int     nErr = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int sat(int n, int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic modelReset();
    mE = '{v: 1'b0, pred: 1'b0, pc: 32'd0};
    mM = '{v: 1'b0, pred: 1'b0, pc: 32'd0, act: 1'b0, tgt: 32'd0};
    squashLeft = 0;
    bcnt = 0;
    mcnt = 0;
  endtask

  task automatic compareAll();
    bit live, mis;
    logic [31:0] red;
    live = mM.v && (squashLeft == 0) && !stallM;
    mis  = live && (mM.pred != mM.act);
    red  = mis ? (mM.act ? mM.tgt : mM.pc + 32'd4) : 32'd0;
    chk("branchM", 32'(branchM), 32'(live));
    chk("actual_takeM", 32'(actual_takeM), 32'(mM.act));
    chk("pcM", pcM, mM.pc);
    chk("mispredictM", 32'(mispredictM), 32'(mis));
    chk("flush_req", 32'(flush_req), 32'(mis));
    chk("redirect_pc", redirect_pc, red);
    chk("recovering", 32'(recovering), 32'(squashLeft > 0));
    chk("branch_cnt", branch_cnt, 32'(bcnt));
    chk("mispred_cnt", mispred_cnt, 32'(mcnt));
    chk("sat_branch_cnt", 32'(sBranchCnt), 32'(sat(bcnt, 7)));
    chk("sat_mispred_cnt", 32'(sMispredCnt), 32'(sat(mcnt, 7)));
  endtask

  task automatic modelEdge();
    bit live, mis;
    eSlot_t nE;
    mSlot_t nM;
    live = mM.v && (squashLeft == 0) && !stallM;
    mis  = live && (mM.pred != mM.act);
    if (flushM || mis) nM = '{v: 1'b0, pred: 1'b0, pc: 32'd0, act: 1'b0, tgt: 32'd0};
    else if (stallM)   nM = mM;
    else               nM = '{v: mE.v, pred: mE.pred, pc: mE.pc, act: actual_takeE, tgt: targetE};
    if (flushE || mis) nE = '{v: 1'b0, pred: 1'b0, pc: 32'd0};
    else if (stallE)   nE = mE;
    else               nE = '{v: branchD, pred: pred_takeD, pc: pcD};
    if (mis)                 squashLeft = RC;
    else if (squashLeft > 0) squashLeft--;
    if (live) bcnt++;
    if (mis)  mcnt++;
    mE = nE;
    mM = nM;
  endtask

  task automatic setIn(bit bD, bit pD, logic [31:0] pc, bit aE, logic [31:0] tE,
                       bit sE = 1'b0, bit fE = 1'b0, bit sM = 1'b0, bit fM = 1'b0);
    branchD = bD; pred_takeD = pD; pcD = pc; actual_takeE = aE; targetE = tE;
    stallE = sE; flushE = fE; stallM = sM; flushM = fM;
  endtask

  task automatic sampleCheck();
    @(negedge clk);
    compareAll();
  endtask

  task automatic advance();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sampleCheck();
    advance();
  endtask

  initial begin
    rst = 1'b0;
    modelReset();
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      setIn($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      sampleCheck();
      chk("rst_branchM", 32'(branchM), 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      @(posedge clk);
      #1;
    end
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    sampleCheck();
    chk("idle_branch_cnt", branch_cnt, 32'd0);
    advance();

    // correct prediction
    setIn(1'b1, 1'b1, 32'h100, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b1, 32'h200); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    sampleCheck();
    chk("ok_branchM", 32'(branchM), 32'd1);
    chk("ok_pcM", pcM, 32'h100);
    chk("ok_mispredict", 32'(mispredictM), 32'd0);
    advance();
    sampleCheck();
    chk("ok_cnt", branch_cnt, 32'd1);
    advance();

    // mispredict not-taken -> taken, with a wrong-path branch in D alongside
    setIn(1'b1, 1'b0, 32'h300, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b1, 32'h400); cyc();
    setIn(1'b1, 1'b1, 32'h500, 1'b1, 32'h600);
    sampleCheck();
    chk("mp_flush", 32'(flush_req), 32'd1);
    chk("mp_redirect", redirect_pc, 32'h400);
    advance();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    sampleCheck();
    chk("mp_flush_pulse", 32'(flush_req), 32'd0);
    chk("mp_recover1", 32'(recovering), 32'd1);
    chk("mp_cnt", mispred_cnt, 32'd1);
    advance();
    sampleCheck();
    chk("mp_recover2", 32'(recovering), 32'd1);
    advance();
    sampleCheck();
    chk("mp_recover_done", 32'(recovering), 32'd0);
    chk("mp_wrongpath", branch_cnt, 32'd2);
    advance();
    cyc(); cyc();

    // taken -> not-taken at the top of the address space
    setIn(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'h1234); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    sampleCheck();
    chk("wrap_flush", 32'(flush_req), 32'd1);
    chk("wrap_redirect", redirect_pc, 32'd0);
    advance();
    for (int i = 0; i < 3; i++) cyc();

    // branch held in M by stallM for three cycles
    setIn(1'b1, 1'b0, 32'h700, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'h800); cyc();
    for (int i = 0; i < 3; i++) begin
      setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      sampleCheck();
      chk("stall_hidden", 32'(branchM), 32'd0);
      advance();
    end
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    sampleCheck();
    chk("stall_release", 32'(branchM), 32'd1);
    chk("stall_pc", pcM, 32'h700);
    advance();
    sampleCheck();
    chk("stall_once", 32'(branchM), 32'd0);
    advance();

    // flushE kills branches entering and sitting in D->E
    setIn(1'b1, 1'b1, 32'h900, 1'b0, 32'd0, 1'b0, 1'b1); cyc();
    setIn(1'b1, 1'b1, 32'hA00, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    sampleCheck();
    chk("flushE_cnt", branch_cnt, 32'd4);
    chk("flushE_mcnt", mispred_cnt, 32'd2);
    advance();

    // reset asserted in the middle of recovery
    setIn(1'b1, 1'b0, 32'h40, 1'b0, 32'd0); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b1, 32'h80); cyc();
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0); cyc();
    sampleCheck();
    chk("midrst_pre", 32'(recovering), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_recover", 32'(recovering), 32'd0);
    chk("midrst_cnt", branch_cnt, 32'd0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      setIn($urandom_range(0, 9) < 6, $urandom_range(0, 1), {$urandom, 2'b00} & 32'hFFFF_FFFC,
            $urandom_range(0, 1), {$urandom, 2'b00} & 32'hFFFF_FFFC,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
      cyc();
    end
    setIn(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    sampleCheck();
    chk("sat_held", 32'(sBranchCnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
